alu_arbiter: RTL

Round-robin arbiter and sequencer that shares the single registered ALU among NREQ requesters. Each requester has a valid/ready request channel (op, A, B) and a valid/ready response channel (Result, ONZ). The block issues one operation at a time, accounts for the ALU's one-cycle registered latency and returns the result to the owner. It also sequences synchronous ONZ-flag clears so that a clear never corrupts an in-flight operation.

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU among NREQ requesters,
// with ONZ clears deferred so they never land on an in-flight operation.
module alu_arbiter #(
   parameter int unsigned N    = 8,
   parameter int unsigned NREQ = 2
) (
   input  logic                clk,
   input  logic                arstn,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [3*NREQ-1:0]   req_op,
   input  logic [N*NREQ-1:0]   req_a,
   input  logic [N*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [N-1:0]        rsp_result,
   output logic [2:0]          rsp_onz,
   input  logic                flag_clr,
   output logic [2:0]          alu_op,
   output logic [N-1:0]        alu_a,
   output logic [N-1:0]        alu_b,
   output logic                alu_en,
   output logic                alu_rst,
   input  logic [N-1:0]        alu_result,
   input  logic [2:0]          alu_onz,
   output logic                busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state;
   logic [IW-1:0]  last;
   logic [IW-1:0]  owner;
   logic           clr_pend;
   logic           grant_vld;
   logic [IW-1:0]  grant_idx;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      int unsigned cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = (32'(last) + k) % NREQ;
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = IW'(cand);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
   end

   // ALU result is already registered; expose it only while a response is offered
   assign rsp_result = (state == RESP) ? alu_result : '0;
   assign rsp_onz    = (state == RESP) ? alu_onz    : 3'b000;
   assign alu_rst    = (state == IDLE) && (flag_clr || clr_pend);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state     <= IDLE;
         last      <= IW'(NREQ - 1);
         owner     <= '0;
         clr_pend  <= 1'b0;
         alu_op    <= 3'b000;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_en    <= 1'b0;
         busy      <= 1'b0;
         rsp_valid <= '0;
      end else begin
         case (state)
            IDLE: begin
               clr_pend <= 1'b0;
               if (grant_vld) begin
                  alu_op <= req_op[32'(grant_idx)*3 +: 3];
                  alu_a  <= req_a[32'(grant_idx)*N +: N];
                  alu_b  <= req_b[32'(grant_idx)*N +: N];
                  owner  <= grant_idx;
                  last   <= grant_idx;
                  alu_en <= 1'b1;
                  busy   <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (flag_clr) clr_pend <= 1'b1;
               alu_en    <= 1'b0;
               rsp_valid <= NREQ'(1) << owner;
               state     <= RESP;
            end
            RESP: begin
               if (flag_clr) clr_pend <= 1'b1;
               // Operands stay held so the ALU result is stable while stalled
               if (rsp_ready[owner]) begin
                  rsp_valid <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
